// File: rtl/sdm_pkg.sv
// sdm_pkg: shared state encoding and sample-format helpers for the sigma-delta PCM blocks
package sdm_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int MAXW = 32;
  function automatic logic [MAXW-1:0] ofs_bin(input logic [MAXW-1:0] s, input int dw);
    return s ^ (MAXW'(1) << (dw - 1));
  endfunction
  function automatic logic [MAXW-1:0] mid_scale(input int dw);
    return MAXW'(1) << (dw - 1);
  endfunction
endpackage

// File: rtl/sdm_fifo.sv
// sdm_fifo: synchronous sample FIFO with flush, occupancy and overflow detect
module sdm_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          fclk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic [AW:0]   level
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   level_q;
  logic          wr, rd;
  assign full  = level_q[AW];
  assign empty = level_q == '0;
  assign level = level_q;
  assign rdata = mem_q[rp_q];
  assign wr    = push && !full && !clear;
  assign rd    = pop && !empty && !clear;
  assign ovf   = push && full && !clear;
  // Data storage only; contents are never read while empty, so no reset
  always_ff @(posedge fclk)
    if (wr) mem_q[wp_q] <= wdata;
  // Pointers and occupancy; a flush wins over any same-cycle push or pop
  always_ff @(posedge fclk or negedge rstn)
    if (!rstn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else if (clear) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_q + AW'(wr);
      rp_q    <= rp_q + AW'(rd);
      level_q <= level_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/sdm_pcm_tx.sv
// sdm_pcm_tx: first-order sigma-delta PCM-to-bitstream transmitter with input sample FIFO
module sdm_pcm_tx
  import sdm_pkg::*;
#(
  parameter int DW   = 8,
  parameter int AW   = 2,
  parameter int CMSB = 12,
  parameter int OSRW = 4
) (
  input  logic            rstn,
  input  logic            fclk,
  input  logic            clear,
  input  logic            en,
  input  logic            push,
  input  logic [DW-1:0]   wdata,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     level,
  input  logic [CMSB:0]   div,
  input  logic [OSRW-1:0] osr,
  output logic            tx,
  output logic            bit_stb,
  output logic            smp_stb,
  output logic            busy,
  output logic            underrun,
  output logic            overflow
);
  localparam logic [DW-1:0] MID = DW'(mid_scale(DW));
  state_e          state_q;
  logic [DW-1:0]   acc_q, smp_q, smp_d, rdata;
  logic [CMSB:0]   bit_cnt_q;
  logic [OSRW-1:0] osr_cnt_q;
  logic            tx_q, underrun_q, overflow_q;
  logic            ovf, pop, tick, bnd, start;
  logic [DW:0]     sum;

  sdm_fifo #(.DW(DW), .AW(AW)) u_fifo (
    .fclk  (fclk),
    .rstn  (rstn),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .level (level)
  );

  assign start    = state_q == IDLE && en && !empty && !clear;
  assign tick     = state_q == RUN && bit_cnt_q == '0 && !clear;
  assign bnd      = tick && osr_cnt_q == '0;
  assign pop      = start || (bnd && en && !empty);
  assign smp_d    = empty ? MID : DW'(ofs_bin(MAXW'(rdata), DW));
  assign sum      = {1'b0, acc_q} + {1'b0, smp_q};
  assign tx       = tx_q;
  assign busy     = state_q == RUN;
  assign bit_stb  = tick;
  assign smp_stb  = pop;
  assign underrun = underrun_q;
  assign overflow = overflow_q;

  // Sequencer: sample loading, bit ticks, error-feedback accumulation and sticky flags
  always_ff @(posedge fclk or negedge rstn)
    if (!rstn) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      osr_cnt_q  <= '0;
      tx_q       <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      osr_cnt_q  <= '0;
      tx_q       <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (ovf) overflow_q <= 1'b1;
      if (start) begin
        state_q   <= RUN;
        smp_q     <= smp_d;
        bit_cnt_q <= div;
        osr_cnt_q <= osr;
      end else if (tick) begin
        {tx_q, acc_q} <= sum;
        bit_cnt_q     <= div;
        osr_cnt_q     <= osr_cnt_q - OSRW'(1);
        if (bnd && !en) begin
          state_q <= IDLE;
          tx_q    <= 1'b0;
        end else if (bnd) begin
          osr_cnt_q <= osr;
          smp_q     <= smp_d;
          if (empty) underrun_q <= 1'b1;
        end
      end else if (state_q == RUN) begin
        bit_cnt_q <= bit_cnt_q - (CMSB+1)'(1);
      end
    end
endmodule

// File: tb/tb_sdm_pcm_tx.sv
// tb_sdm_pcm_tx: scoreboard bench for the sigma-delta PCM transmitter
module tb_sdm_pcm_tx;
  localparam int DW = 4, AW = 2, CMSB = 12, OSRW = 4, NB = 16;
  logic            fclk = 1'b0, rstn = 1'b0, clear = 1'b0, en = 1'b0, push = 1'b0;
  logic [DW-1:0]   wdata = '0;
  logic [CMSB:0]   div = '0;
  logic [OSRW-1:0] osr = 4'd15;
  logic            full, empty, tx, bit_stb, smp_stb, busy, underrun, overflow;
  logic [AW:0]     level;
  int n_tests = 0, n_fail = 0;
  bit pacc = 1'b0;
  int q[$];
  int cur_u = 0, macc = 0, idx = 0, s = 0;
  bit run = 0, pend = 0, pexp = 0, ptx = 0, pbs = 0, pclr = 0;

  sdm_pcm_tx #(.DW(DW), .AW(AW), .CMSB(CMSB), .OSRW(OSRW)) dut (
    .rstn(rstn), .fclk(fclk), .clear(clear), .en(en), .push(push), .wdata(wdata),
    .full(full), .empty(empty), .level(level), .div(div), .osr(osr), .tx(tx),
    .bit_stb(bit_stb), .smp_stb(smp_stb), .busy(busy), .underrun(underrun), .overflow(overflow)
  );

  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_smp(input int v, input bit a);
    @(posedge fclk); #1;
    push = 1'b1; wdata = v[DW-1:0]; pacc = a;
    @(posedge fclk); #1;
    push = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    while (busy && t < lim) begin @(negedge fclk); t++; end
    chk("idle_wait", busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx"}, tx, 0);
    chk({tag, "_bit_stb"}, bit_stb, 0);
    chk({tag, "_smp_stb"}, smp_stb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_level"}, level, 0);
  endtask

  // Scoreboard monitor: expected samples queued on push, bits predicted per tick
  always @(negedge fclk) begin
    if (pend && rstn) chk("tx_bit", tx, pexp);
    if (rstn && tx !== ptx) chk("tx_hold", pbs | pclr, 1);
    pend = 0; ptx = tx; pbs = bit_stb; pclr = clear;
    if (!rstn || clear) begin
      q.delete(); macc = 0; idx = 0; run = 0;
    end else begin
      if (smp_stb && !run) begin
        if (q.size() == 0) chk("smp_stb_start", 1, 0);
        else cur_u = q.pop_front();
        idx = 0; run = 1;
      end
      if (bit_stb) begin
        s = macc + cur_u;
        pexp = s >= 2**DW;
        macc = s % 2**DW;
        idx++;
        if (idx == NB) begin
          idx = 0;
          if (!en) begin
            run = 0; pexp = 0;
          end else begin
            chk("smp_stb_bnd", smp_stb, q.size() != 0);
            cur_u = q.size() != 0 ? q.pop_front() : 2**(DW-1);
          end
        end
        pend = 1;
      end
      if (push && pacc) q.push_back(int'($signed(wdata)) + 2**(DW-1));
    end
  end

  initial begin
    int t, nb, last, ones;
    repeat (2) @(posedge fclk); #1;
    chk_reset_vals("rst");
    rstn = 1'b1;
    en = 1'b1;
    @(posedge fclk); #1;
    push = 1'b1; wdata = 4'h8; pacc = 1'b1;
    @(negedge fclk);
    chk("empty_c0", empty, 1);
    @(posedge fclk); #1;
    push = 1'b0;
    @(negedge fclk);
    chk("empty_c1", empty, 0);
    chk("smp_stb_c1", smp_stb, 1);
    chk("busy_c1", busy, 0);
    @(negedge fclk);
    chk("busy_c2", busy, 1);
    chk("bit_stb_c2", bit_stb, 1);
    push_smp(7, 1);
    push_smp(0, 1);
    repeat (50) @(negedge fclk);
    chk("underrun_set", underrun, 1);
    chk("busy_underrun", busy, 1);
    push_smp(3, 1);
    repeat (40) @(negedge fclk);

    en = 1'b0;
    wait_idle(64);
    div = 3;
    push_smp(0, 1);
    push_smp(0, 1);
    @(posedge fclk); #1;
    en = 1'b1;
    @(negedge fclk);
    chk("start_stb", smp_stb, 1);
    t = 0; nb = 0; last = 0;
    do begin
      @(negedge fclk); t++;
      if (bit_stb) begin chk("bit_gap", t - last, 4); last = t; nb++; end
    end while (!smp_stb && t < 100);
    chk("smp_period", t, 64);
    chk("bits_per_smp", nb, 16);
    repeat (70) @(negedge fclk);
    en = 1'b0;
    wait_idle(300);

    div = 0;
    push_smp(-8, 1);
    push_smp(-4, 1);
    push_smp(2, 1);
    push_smp(5, 1);
    chk("full_4", full, 1);
    chk("level_4", level, 4);
    chk("ovf_pre", overflow, 0);
    push_smp(7, 0);
    chk("ovf_5", overflow, 1);
    chk("level_5", level, 4);
    @(posedge fclk); #1;
    en = 1'b1;
    repeat (90) @(negedge fclk);
    en = 1'b0;
    wait_idle(40);

    div = 3;
    push_smp(1, 1);
    push_smp(-3, 1);
    push_smp(6, 1);
    push_smp(-1, 1);
    chk("underrun_pre_clr", underrun, 1);
    chk("overflow_pre_clr", overflow, 1);
    @(posedge fclk); #1;
    en = 1'b1;
    repeat (12) @(negedge fclk);
    chk("level_pre_clr", level, 3);
    chk("busy_pre_clr", busy, 1);
    @(posedge fclk); #1;
    clear = 1'b1;
    @(posedge fclk); #1;
    clear = 1'b0;
    @(negedge fclk);
    chk_reset_vals("clr");

    push_smp(2, 1);
    repeat (6) @(negedge fclk);
    chk("busy_pre_rst", busy, 1);
    @(posedge fclk); #2;
    rstn = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge fclk);
    @(posedge fclk); #3;
    rstn = 1'b1;
    div = 0;
    push_smp(7, 1);
    @(negedge fclk);
    chk("rst_resume_stb", smp_stb, 1);
    @(negedge fclk);
    ones = 0;
    repeat (16) begin @(negedge fclk); ones += int'(tx); end
    chk("ones_7", ones, 15);
    en = 1'b0;
    wait_idle(40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
